trap_ctrl: RTL

Machine-mode trap sequencer for the RV32 core. It arbitrates between synchronous exceptions, `mret`, and the three machine interrupt lines, and drains the pipeline through a flush handshake. It commits the trap CSRs (`mepc`, `mcause`, `mtval`, `mstatus.MIE/MPIE`), then issues a single PC redirect to fetch. It sits beside the CSR file and owns only those trap fields; `mtvec` and `mie` arrive as inputs from the CSR file.

---
 rtl/trap_ctrl_if.sv | 44 ++++
 rtl/trap_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - trap sequencer event, CSR and pipeline handshake bundle
interface trap_ctrl_if;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_valid;
    logic        irq_meip;
    logic        irq_mtip;
    logic        irq_msip;
    logic [31:0] int_pc;
    logic [31:0] mtvec;
    logic [31:0] mie;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        pipe_drained;
    logic        redirect_ready;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;

    modport slave (
        input  exc_valid, exc_code, exc_pc, exc_tval, mret_valid,
        input  irq_meip, irq_mtip, irq_msip, int_pc, mtvec, mie,
        input  csr_we, csr_addr, csr_wdata, pipe_drained, redirect_ready,
        output flush, redirect_valid, redirect_pc, busy,
        output mepc_q, mcause_q, mtval_q, mstatus_mie_q, mstatus_mpie_q
    );

    modport master (
        output exc_valid, exc_code, exc_pc, exc_tval, mret_valid,
        output irq_meip, irq_mtip, irq_msip, int_pc, mtvec, mie,
        output csr_we, csr_addr, csr_wdata, pipe_drained, redirect_ready,
        input  flush, redirect_valid, redirect_pc, busy,
        input  mepc_q, mcause_q, mtval_q, mstatus_mie_q, mstatus_mpie_q
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer (optional TRAP_VECTORED_EN)
module trap_ctrl #(
    parameter int          XLEN       = 32,
    parameter logic [31:0] RESET_MEPC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_COMMIT, S_REDIRECT} state_t;
    typedef enum logic [1:0] {EV_EXC, EV_MRET, EV_IRQ} ev_t;

    state_t            state_q, state_d;
    ev_t               ev_kind_q, ev_kind_d;
    logic [4:0]        ev_code_q, ev_code_d;
    logic [XLEN-1:0]   ev_pc_q, ev_pc_d;
    logic [XLEN-1:0]   ev_tval_q, ev_tval_d;
    logic [XLEN-1:0]   mepc_q, mepc_d;
    logic [XLEN-1:0]   mcause_q, mcause_d;
    logic [XLEN-1:0]   mtval_q, mtval_d;
    logic              mie_q, mie_d;
    logic              mpie_q, mpie_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic              busy_q, busy_d;

    logic [2:0]        irq_en;
    logic [4:0]        irq_code;
    logic [XLEN-1:0]   trap_base;
    logic [XLEN-1:0]   vec_off;

    // Bits of the inputs that carry no meaning here (alignment bits, other mie enables).
    logic unused_bits;
    assign unused_bits = ^{bus.mie[31:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0],
                           bus.exc_pc[1:0], bus.int_pc[1:0], bus.mtvec[1:0]};

    // Next-state, event latching and CSR update logic for the whole trap sequence.
    always_comb begin
        state_d       = state_q;
        ev_kind_d     = ev_kind_q;
        ev_code_d     = ev_code_q;
        ev_pc_d       = ev_pc_q;
        ev_tval_d     = ev_tval_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        redirect_pc_d = redirect_pc_q;

        irq_en    = {bus.irq_meip & bus.mie[11], bus.irq_msip & bus.mie[3], bus.irq_mtip & bus.mie[7]};
        irq_code  = irq_en[2] ? 5'd11 : (irq_en[1] ? 5'd3 : 5'd7);
        trap_base = {bus.mtvec[31:2], 2'b00};
        vec_off   = '0;
`ifdef TRAP_VECTORED_EN
        if (bus.mtvec[1:0] == 2'b01) vec_off = {25'b0, ev_code_q, 2'b00};
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.exc_valid) begin
                    state_d   = S_FLUSH;
                    ev_kind_d = EV_EXC;
                    ev_code_d = bus.exc_code;
                    ev_pc_d   = bus.exc_pc;
                    ev_tval_d = bus.exc_tval;
                end else if (bus.mret_valid) begin
                    state_d   = S_FLUSH;
                    ev_kind_d = EV_MRET;
                end else if (mie_q && (irq_en != 3'b000)) begin
                    state_d   = S_FLUSH;
                    ev_kind_d = EV_IRQ;
                    ev_code_d = irq_code;
                    ev_pc_d   = bus.int_pc;
                    ev_tval_d = '0;
                end else if (bus.csr_we) begin
                    case (bus.csr_addr)
                        12'h300: begin
                            mie_d  = bus.csr_wdata[3];
                            mpie_d = bus.csr_wdata[7];
                        end
                        12'h341: mepc_d   = {bus.csr_wdata[31:2], 2'b00};
                        12'h342: mcause_d = bus.csr_wdata;
                        12'h343: mtval_d  = bus.csr_wdata;
                        default: ;
                    endcase
                end
            end
            S_FLUSH: begin
                if (bus.pipe_drained) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d = S_REDIRECT;
                if (ev_kind_q == EV_MRET) begin
                    mie_d         = mpie_q;
                    mpie_d        = 1'b1;
                    redirect_pc_d = mepc_q;
                end else begin
                    mepc_d        = {ev_pc_q[31:2], 2'b00};
                    mtval_d       = ev_tval_q;
                    mpie_d        = mie_q;
                    mie_d         = 1'b0;
                    if (ev_kind_q == EV_IRQ) begin
                        mcause_d      = {1'b1, 26'b0, ev_code_q};
                        redirect_pc_d = trap_base + vec_off;
                    end else begin
                        mcause_d      = {27'b0, ev_code_q};
                        redirect_pc_d = trap_base;
                    end
                end
            end
            S_REDIRECT: begin
                if (bus.redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        flush_d          = (state_d == S_FLUSH);
        redirect_valid_d = (state_d == S_REDIRECT);
        busy_d           = (state_d != S_IDLE);
    end

    // Sequencer state, latched event and trap CSRs with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            ev_kind_q        <= EV_EXC;
            ev_code_q        <= '0;
            ev_pc_q          <= '0;
            ev_tval_q        <= '0;
            mepc_q           <= RESET_MEPC;
            mcause_q         <= '0;
            mtval_q          <= '0;
            mie_q            <= 1'b0;
            mpie_q           <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            ev_kind_q        <= ev_kind_d;
            ev_code_q        <= ev_code_d;
            ev_pc_q          <= ev_pc_d;
            ev_tval_q        <= ev_tval_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            mie_q            <= mie_d;
            mpie_q           <= mpie_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            busy_q           <= busy_d;
        end
    end

    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.busy           = busy_q;
    assign bus.mepc_q         = mepc_q;
    assign bus.mcause_q       = mcause_q;
    assign bus.mtval_q        = mtval_q;
    assign bus.mstatus_mie_q  = mie_q;
    assign bus.mstatus_mpie_q = mpie_q;

endmodule
